ctrl_seq: RTL



---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/instr_decode.sv | 36 +++
 rtl/ctrl_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcodes, ALU operation
// codes, register codes, sequencer state codes and decode classes.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_CMP = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_DEC = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JC  = 4'hD;
  localparam logic [3:0] OP_RSV = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_INC = 3'd5;
  localparam logic [2:0] ALU_DEC = 3'd6;

  localparam logic [1:0] REG_AL = 2'd0;
  localparam logic [1:0] REG_BL = 2'd1;
  localparam logic [1:0] REG_CL = 2'd2;
  localparam logic [1:0] REG_DL = 2'd3;

  // Sequencer state codes
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_OPB    = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_IMM    = 3'd5;
  localparam logic [2:0] ST_IMMX   = 3'd6;
  localparam logic [2:0] ST_HALT   = 3'd7;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_MOV,
    CLS_ALU2,
    CLS_ALU1,
    CLS_IMM,
    CLS_JUMP,
    CLS_HALT
  } op_class_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode classifier: maps IR[7:4] to an execution class,
// the ALU operation, and whether the instruction writes dst / updates flags.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  output op_class_t  cls,
  output logic [2:0] alu_op,
  output logic       writes_dst,
  output logic       sets_flags
);

  // Opcode to class / ALU operation lookup
  always_comb begin
    cls        = CLS_NOP;
    alu_op     = ALU_ADD;
    writes_dst = 1'b0;
    sets_flags = 1'b0;
    case (op)
      OP_MOV: begin cls = CLS_MOV;  writes_dst = 1'b1; end
      OP_LDI: begin cls = CLS_IMM;  writes_dst = 1'b1; end
      OP_ADD: begin cls = CLS_ALU2; alu_op = ALU_ADD; writes_dst = 1'b1; sets_flags = 1'b1; end
      OP_SUB: begin cls = CLS_ALU2; alu_op = ALU_SUB; writes_dst = 1'b1; sets_flags = 1'b1; end
      OP_AND: begin cls = CLS_ALU2; alu_op = ALU_AND; writes_dst = 1'b1; sets_flags = 1'b1; end
      OP_OR:  begin cls = CLS_ALU2; alu_op = ALU_OR;  writes_dst = 1'b1; sets_flags = 1'b1; end
      OP_XOR: begin cls = CLS_ALU2; alu_op = ALU_XOR; writes_dst = 1'b1; sets_flags = 1'b1; end
      OP_CMP: begin cls = CLS_ALU2; alu_op = ALU_SUB; sets_flags = 1'b1; end
      OP_INC: begin cls = CLS_ALU1; alu_op = ALU_INC; writes_dst = 1'b1; sets_flags = 1'b1; end
      OP_DEC: begin cls = CLS_ALU1; alu_op = ALU_DEC; writes_dst = 1'b1; sets_flags = 1'b1; end
      OP_JMP, OP_JZ, OP_JC: cls = CLS_JUMP;
      OP_HLT: cls = CLS_HALT;
      default: cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Fetch/decode/execute control sequencer for the 8-bit CPU. Owns PC, IR,
// the immediate latch and Z/C flags; drives register-file, ALU-latch and
// bus-driver strobes as a decode of state and IR.
// Optional: CTRL_SEQ_STEP_EN adds a 'step' input that gates each FETCH.
module ctrl_seq
  import cpu_pkg::*;
#(
  parameter int unsigned        PC_W     = 8,
  parameter logic [PC_W-1:0]    RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
`ifdef CTRL_SEQ_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] instr_addr,
  output logic            instr_req,
  input  logic            instr_ack,
  input  logic [7:0]      instr_data,
  input  logic            alu_z,
  input  logic            alu_c,
  output logic            reg_r,
  output logic [7:0]      reg_r_select,
  output logic            reg_w,
  output logic [7:0]      reg_w_select,
  output logic            tmp_w,
  output logic            acc_w,
  output logic [2:0]      alu_op,
  output logic            alu_r,
  output logic            imm_r,
  output logic [7:0]      imm_out,
  output logic            flag_z,
  output logic            flag_c,
  output logic            halted
);

  logic [2:0]      state;
  logic [PC_W-1:0] pc;
  logic [7:0]      ir;
  logic [7:0]      imm;
  op_class_t       cls;
  logic [2:0]      dec_alu_op;
  logic            writes_dst;
  logic            sets_flags;
  logic [1:0]      dst;
  logic [1:0]      src;
  logic [1:0]      rsel;
  logic            fetch_go;
  logic            ack_take;
  logic            jump_taken;

  assign dst = ir[3:2];
  assign src = ir[1:0];

  instr_decode u_decode (
    .op         (ir[7:4]),
    .cls        (cls),
    .alu_op     (dec_alu_op),
    .writes_dst (writes_dst),
    .sets_flags (sets_flags)
  );

`ifdef CTRL_SEQ_STEP_EN
  logic armed;

  // One-deep step memory: set by any step pulse, consumed by an opcode fetch
  always_ff @(posedge clk) begin
    if (reset) armed <= 1'b0;
    else       armed <= step | (armed & ~(state == ST_FETCH && ack_take));
  end

  assign fetch_go = armed;
`else
  assign fetch_go = 1'b1;
`endif

  assign ack_take   = instr_req & instr_ack;
  assign jump_taken = (ir[7:4] == OP_JMP) ||
                      (ir[7:4] == OP_JZ && flag_z) ||
                      (ir[7:4] == OP_JC && flag_c);

  // Architectural state and sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      imm    <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: if (ack_take) begin
          ir    <= instr_data;
          pc    <= pc + PC_W'(1);
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          case (cls)
            CLS_ALU2:          state <= ST_OPB;
            CLS_ALU1:          state <= ST_EXEC;
            CLS_IMM, CLS_JUMP: state <= ST_IMM;
            CLS_HALT:          state <= ST_HALT;
            default:           state <= ST_FETCH;
          endcase
        end
        ST_OPB:  state <= ST_EXEC;
        ST_EXEC: state <= ST_WB;
        ST_WB: begin
          if (sets_flags) begin
            flag_z <= alu_z;
            flag_c <= alu_c;
          end
          state <= ST_FETCH;
        end
        ST_IMM: if (ack_take) begin
          imm   <= instr_data;
          pc    <= pc + PC_W'(1);
          state <= ST_IMMX;
        end
        ST_IMMX: begin
          if (cls == CLS_JUMP && jump_taken) pc <= PC_W'(imm);
          state <= ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Strobe decode; everything held low while reset is asserted
  always_comb begin
    instr_req = 1'b0;
    reg_r     = 1'b0;
    reg_w     = 1'b0;
    tmp_w     = 1'b0;
    acc_w     = 1'b0;
    alu_r     = 1'b0;
    imm_r     = 1'b0;
    rsel      = src;
    if (!reset) begin
      case (state)
        ST_FETCH:  instr_req = fetch_go;
        ST_IMM:    instr_req = 1'b1;
        ST_DECODE: if (cls == CLS_MOV) begin
          reg_r = 1'b1;
          reg_w = 1'b1;
        end
        ST_OPB: begin
          reg_r = 1'b1;
          tmp_w = 1'b1;
        end
        ST_EXEC: begin
          reg_r = 1'b1;
          rsel  = dst;
          acc_w = 1'b1;
        end
        ST_WB: begin
          alu_r = 1'b1;
          reg_w = writes_dst;
        end
        ST_IMMX: if (cls == CLS_IMM) begin
          imm_r = 1'b1;
          reg_w = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign instr_addr   = pc;
  assign reg_r_select = {6'b0, rsel};
  assign reg_w_select = {6'b0, dst};
  assign alu_op       = dec_alu_op;
  assign imm_out      = imm;
  assign halted       = (state == ST_HALT);

endmodule
